pipelined_control_unit: RTL
===========================

# pipelined_control_unit

Parametrised, pipelined successor to the single-stage control decoder of the 5-stage RV32I core. Decodes the instruction in ID, registers the control bundle through ID/EX, EX/MEM and MEM/WB, and resolves branch/jump redirection in EX from ALU flags. Supports the full RV32I branch set, LUI/AUIPC/JALR, and a bubble-inserting flush. It replaces the per-stage control flops currently spread across the datapath.

## Interface
- ALU_CTRL_W, 4, width of the ALU control code; legal range 4..8; codes are zero-extended above bit 3.
- EN_BRANCH_EXT, 1, 1 = BEQ/BNE/BLT/BGE/BLTU/BGEU; 0 = BEQ only, other branches flagged illegal.
- clk  in  1  single core clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_d  in  32  instruction held in ID.
- flush_e  in  1  insert a bubble into ID/EX at the next edge.
- zero_e, lt_e, ltu_e  in  1 each  ALU flags for the EX instruction: equal, signed less-than, unsigned less-than.
- imm_src_d  out  3  combinational: 0=I, 1=S, 2=B, 3=J, 4=U.
- rs1_used_d, rs2_used_d  out  1 each  combinational register-read flags for the hazard unit.
- illegal_d  out  1  combinational: unsupported opcode/funct.
- alu_control_e  out  ALU_CTRL_W  registered.
- alu_src_e  out  1  registered: 0=rs2, 1=immediate.
- alu_a_src_e  out  2  registered: 0=rs1, 1=PC, 2=zero.
- pc_target_src_e  out  1  registered: 0=PC+imm, 1=rs1+imm (JALR).
- pc_src_e  out  1  combinational from EX state and flags.
- result_src_e, result_src_m, result_src_w  out  2 each  0=ALU, 1=memory, 2=PC+4.
- reg_write_e, reg_write_m, reg_write_w  out  1 each.
- mem_write_e, mem_write_m  out  1 each.

## Operation
- Decode by opcode: R (0110011), I-ALU (0010011), load (0000011), store (0100011), branch (1100011), JAL (1101111), JALR (1100111), LUI (0110111), AUIPC (0010111). All other opcodes: illegal_d=1; the bundle is all-zero (bubble).
- ALU codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA.
- SUB only for R-type with funct7[5]=1 and funct3=000. SRA for funct3=101 with funct7[5]=1 in both R and I forms.
- SLLI/SRLI/SRAI with any other funct7 bit set are illegal.
- Loads, stores, JALR, AUIPC and LUI use ADD. Branches use SUB.
- LUI: alu_a_src=2, alu_src=1. AUIPC: alu_a_src=1, alu_src=1.
- Branch condition by registered funct3_e:
  - 000: zero_e; 001: !zero_e
  - 100: lt_e; 101: !lt_e
  - 110: ltu_e; 111: !ltu_e
  - 010/011 are illegal in ID.
- pc_src_e = jump_e | (branch_e & cond). With EN_BRANCH_EXT=0, cond = zero_e.
- JAL/JALR: reg_write=1, result_src=2. JALR additionally sets pc_target_src=1.
- rs1_used_d=0 for JAL/LUI/AUIPC. rs2_used_d=1 only for R, store and branch.

## Timing
- rst asserted: every registered field in all three stages clears to 0 immediately. pc_src_e=0 and all registered outputs read 0.
- Latency: decode of instr_d appears on *_e one edge later, *_m two edges later, *_w three edges later.
- EX/MEM and MEM/WB advance every cycle; there is no stall input. Holding ID is the hazard unit's job through the IF/ID enable.
- flush_e=1 at an edge: ID/EX loads the all-zero bubble, including branch_e, jump_e and funct3_e. The instruction leaving EX still moves into MEM normally.
- flush_e in the same cycle as pc_src_e=1: the current EX instruction still redirects that cycle, and the next EX is a bubble.
- Illegal instruction in ID: it propagates as a bubble; illegal_d is high only while the instruction sits in ID.
- rst mid-stream: in-flight reg_write_m/w and mem_write_m drop asynchronously; no partial write is issued after reset.

## Test plan
- Reset: assert rst mid-pipeline with an SW in MEM -> mem_write_m=0 before the next edge; all outputs 0.
- R-type SUB (0x40208033) -> 1 cycle later alu_control_e=1, reg_write_e=1, alu_src_e=0; reg_write_w=1 three edges after entry.
- BLT (funct3=100): lt_e=1 gives pc_src_e=1, lt_e=0 gives 0. With EN_BRANCH_EXT=0, illegal_d=1 and pc_src_e stays 0.
- JALR (0x000080E7) -> pc_target_src_e=1, pc_src_e=1 regardless of flags, result_src_e=2; LUI -> alu_a_src_e=2.
- Load then flush_e=1 on the next edge -> the following EX bundle is all zero, while the load reaches MEM with result_src_m=1.
- Opcode 0x7F -> illegal_d=1, and no reg_write/mem_write appears in any later stage.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// RV32I control decoder with the control bundle carried through ID/EX, EX/MEM
// and MEM/WB; branch/jump redirection is resolved in EX from the ALU flags.
module pipelined_control_unit #(
  parameter int ALU_CTRL_W    = 4,
  parameter bit EN_BRANCH_EXT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           i_instr_d,
  input  logic                  i_flush_e,
  input  logic                  i_zero_e,
  input  logic                  i_lt_e,
  input  logic                  i_ltu_e,
  output logic [2:0]            o_imm_src_d,
  output logic                  o_rs1_used_d,
  output logic                  o_rs2_used_d,
  output logic                  o_illegal_d,
  output logic [ALU_CTRL_W-1:0] o_alu_control_e,
  output logic                  o_alu_src_e,
  output logic [1:0]            o_alu_a_src_e,
  output logic                  o_pc_target_src_e,
  output logic                  o_pc_src_e,
  output logic [1:0]            o_result_src_e,
  output logic [1:0]            o_result_src_m,
  output logic [1:0]            o_result_src_w,
  output logic                  o_reg_write_e,
  output logic                  o_reg_write_m,
  output logic                  o_reg_write_w,
  output logic                  o_mem_write_e,
  output logic                  o_mem_write_m
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic [1:0] alu_a_src;
    logic       pc_target_src;
    logic [2:0] funct3;
  } ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
  } ctrl_m_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } ctrl_w_t;

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_f7_alt;
  logic       w_f7_zero;
  logic       w_unused;

  assign w_op      = i_instr_d[6:0];
  assign w_f3      = i_instr_d[14:12];
  assign w_f7      = i_instr_d[31:25];
  assign w_f7_zero = (w_f7 == 7'b0000000);
  assign w_f7_alt  = (w_f7 == 7'b0100000);
  assign w_unused  = ^{i_instr_d[24:15], i_instr_d[11:7]};

  ctrl_t      w_dec;
  ctrl_t      w_dec_q;
  logic       w_illegal;
  logic [2:0] w_imm_src;
  logic       w_rs1_used;
  logic       w_rs2_used;

  always_comb begin
    w_dec      = '0;
    w_illegal  = 1'b0;
    w_imm_src  = 3'd0;
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    w_dec.funct3 = w_f3;
    unique case (w_op)
      OP_R: begin
        w_dec.reg_write = 1'b1;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        // Only SUB and SRA accept the alternate funct7 encoding
        if (!(w_f7_zero || (w_f7_alt && (w_f3 == 3'b000 || w_f3 == 3'b101))))
          w_illegal = 1'b1;
        unique case (w_f3)
          3'b000:  w_dec.alu_ctrl = w_f7_alt ? ALU_SUB : ALU_ADD;
          3'b001:  w_dec.alu_ctrl = ALU_SLL;
          3'b010:  w_dec.alu_ctrl = ALU_SLT;
          3'b011:  w_dec.alu_ctrl = ALU_SLTU;
          3'b100:  w_dec.alu_ctrl = ALU_XOR;
          3'b101:  w_dec.alu_ctrl = w_f7_alt ? ALU_SRA : ALU_SRL;
          3'b110:  w_dec.alu_ctrl = ALU_OR;
          default: w_dec.alu_ctrl = ALU_AND;
        endcase
      end
      OP_I: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_rs1_used = 1'b1;
        unique case (w_f3)
          3'b000:  w_dec.alu_ctrl = ALU_ADD;
          3'b001: begin
            w_dec.alu_ctrl = ALU_SLL;
            w_illegal = !w_f7_zero;
          end
          3'b010:  w_dec.alu_ctrl = ALU_SLT;
          3'b011:  w_dec.alu_ctrl = ALU_SLTU;
          3'b100:  w_dec.alu_ctrl = ALU_XOR;
          3'b101: begin
            w_dec.alu_ctrl = w_f7_alt ? ALU_SRA : ALU_SRL;
            w_illegal = !(w_f7_zero || w_f7_alt);
          end
          3'b110:  w_dec.alu_ctrl = ALU_OR;
          default: w_dec.alu_ctrl = ALU_AND;
        endcase
      end
      OP_LOAD: begin
        w_dec.reg_write  = 1'b1;
        w_dec.result_src = RES_MEM;
        w_dec.alu_src    = 1'b1;
        w_rs1_used = 1'b1;
        w_illegal  = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
      end
      OP_STORE: begin
        w_dec.mem_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_imm_src  = 3'd1;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_illegal  = w_f3[2] || (w_f3[1:0] == 2'b11);
      end
      OP_BRANCH: begin
        w_dec.branch   = 1'b1;
        w_dec.alu_ctrl = ALU_SUB;
        w_imm_src  = 3'd2;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        if (EN_BRANCH_EXT) w_illegal = (w_f3[2:1] == 2'b01);
        else               w_illegal = (w_f3 != 3'b000);
      end
      OP_JAL: begin
        w_dec.jump       = 1'b1;
        w_dec.reg_write  = 1'b1;
        w_dec.result_src = RES_PC4;
        w_imm_src = 3'd3;
      end
      OP_JALR: begin
        w_dec.jump          = 1'b1;
        w_dec.reg_write     = 1'b1;
        w_dec.result_src    = RES_PC4;
        w_dec.alu_src       = 1'b1;
        w_dec.pc_target_src = 1'b1;
        w_rs1_used = 1'b1;
        w_illegal  = (w_f3 != 3'b000);
      end
      OP_LUI: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_a_src = 2'd2;
        w_imm_src = 3'd4;
      end
      OP_AUIPC: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_a_src = 2'd1;
        w_imm_src = 3'd4;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // An illegal instruction travels as a bubble and reports no register reads
  assign w_dec_q      = w_illegal ? '0 : w_dec;
  assign o_illegal_d  = w_illegal;
  assign o_imm_src_d  = w_imm_src;
  assign o_rs1_used_d = w_rs1_used & ~w_illegal;
  assign o_rs2_used_d = w_rs2_used & ~w_illegal;

  ctrl_t   r_e;
  ctrl_m_t r_m;
  ctrl_w_t r_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_e <= i_flush_e ? '0 : w_dec_q;
      r_m <= '{reg_write: r_e.reg_write, result_src: r_e.result_src,
               mem_write: r_e.mem_write};
      r_w <= '{reg_write: r_m.reg_write, result_src: r_m.result_src};
    end
  end

  logic w_cond;

  always_comb begin
    w_cond = i_zero_e;
    if (EN_BRANCH_EXT) begin
      unique case (r_e.funct3)
        3'b000:  w_cond = i_zero_e;
        3'b001:  w_cond = ~i_zero_e;
        3'b100:  w_cond = i_lt_e;
        3'b101:  w_cond = ~i_lt_e;
        3'b110:  w_cond = i_ltu_e;
        3'b111:  w_cond = ~i_ltu_e;
        default: w_cond = 1'b0;
      endcase
    end
  end

  assign o_pc_src_e        = r_e.jump | (r_e.branch & w_cond);
  assign o_alu_control_e   = ALU_CTRL_W'(r_e.alu_ctrl);
  assign o_alu_src_e       = r_e.alu_src;
  assign o_alu_a_src_e     = r_e.alu_a_src;
  assign o_pc_target_src_e = r_e.pc_target_src;
  assign o_result_src_e    = r_e.result_src;
  assign o_reg_write_e     = r_e.reg_write;
  assign o_mem_write_e     = r_e.mem_write;
  assign o_result_src_m    = r_m.result_src;
  assign o_reg_write_m     = r_m.reg_write;
  assign o_mem_write_m     = r_m.mem_write;
  assign o_result_src_w    = r_w.result_src;
  assign o_reg_write_w     = r_w.reg_write;

endmodule
